// File: rtl/mult_pipelined.sv
// Unsigned BITS x BITS shift-add multiplier, one pipeline stage per multiplier bit.
// Accepts one operation per cycle and returns results in issue order after BITS edges.
module mult_pipelined #(
    parameter int BITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [BITS-1:0]     multiplicand,
    input  logic [BITS-1:0]     multiplier,
    output logic [2*BITS-1:0]   product,
    output logic                zero_operand,
    output logic                data_valid
);

    localparam int PW = 2 * BITS;
    localparam int NS = BITS - 1;

    logic [NS-1:0]   r_valid;
    logic [BITS-1:0] r_a   [NS];
    logic [BITS-1:0] r_b   [NS];
    logic [PW-1:0]   r_sum [NS];

    logic [PW-1:0]   w_addend [BITS];
    logic [PW-1:0]   w_next   [BITS];

    // Stage i contributes A << i when bit i of B is set; the final stage feeds the output flops.
    for (genvar i = 0; i < BITS; i++) begin : g_stage
        if (i == 0) begin : g_first
            assign w_addend[i] = multiplier[0] ? {{BITS{1'b0}}, multiplicand} : '0;
            assign w_next[i]   = w_addend[i];
        end else begin : g_rest
            assign w_addend[i] = r_b[i-1][i] ? ({{BITS{1'b0}}, r_a[i-1]} << i) : '0;
            assign w_next[i]   = r_sum[i-1] + w_addend[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else begin
            r_valid[0] <= start;
            for (int k = 1; k < NS; k++) begin
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    // Data registers need no reset: nothing downstream uses them without a matching valid bit.
    always_ff @(posedge clk) begin
        if (start) begin
            r_a[0]   <= multiplicand;
            r_b[0]   <= multiplier;
            r_sum[0] <= w_next[0];
        end
        for (int k = 1; k < NS; k++) begin
            if (r_valid[k-1]) begin
                r_a[k]   <= r_a[k-1];
                r_b[k]   <= r_b[k-1];
                r_sum[k] <= w_next[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            product      <= '0;
            zero_operand <= 1'b0;
            data_valid   <= 1'b0;
        end else begin
            data_valid <= r_valid[NS-1];
            if (r_valid[NS-1]) begin
                product      <= w_next[BITS-1];
                zero_operand <= (r_a[NS-1] == '0) || (r_b[NS-1] == '0);
            end
        end
    end

endmodule

// File: tb/tb_mult_pipelined.sv
// Self-checking bench for mult_pipelined: directed cases plus a randomized regression
// compared against a queue-based reference model that works from plain multiplication.
module tb_mult_pipelined;

    localparam int BITS = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic [15:0] product;
    logic        zero_operand;
    logic        data_valid;

    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic [7:0]  product4;
    logic        zero4;
    logic        valid4;

    mult_pipelined #(.BITS(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .zero_operand (zero_operand),
        .data_valid   (data_valid)
    );

    mult_pipelined #(.BITS(4)) dut4 (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start4),
        .multiplicand (a4),
        .multiplier   (b4),
        .product      (product4),
        .zero_operand (zero4),
        .data_valid   (valid4)
    );

    typedef struct {
        int unsigned a;
        int unsigned b;
        int unsigned due;
    } op_t;

    op_t         pending[$];
    int unsigned edgeCount;
    logic [15:0] lastProd;
    logic        lastZero;
    int          total;
    int          bad;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // An operation sampled on edge e must be presented right after edge e+BITS-1.
    task automatic checkOutput();
        op_t  op;
        logic expValid;
        expValid = 1'b0;
        if (pending.size() > 0 && pending[0].due == edgeCount) begin
            op       = pending.pop_front();
            expValid = 1'b1;
            lastProd = 16'(op.a * op.b);
            lastZero = (op.a == 0) || (op.b == 0);
        end
        checkEq("data_valid", {31'd0, data_valid}, {31'd0, expValid});
        checkEq("product", {16'd0, product}, {16'd0, lastProd});
        checkEq("zero_operand", {31'd0, zero_operand}, {31'd0, lastZero});
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] a, input logic [7:0] b);
        op_t op;
        start        = s;
        multiplicand = a;
        multiplier   = b;
        @(posedge clk);
        #1;
        edgeCount++;
        if (s) begin
            op.a   = a;
            op.b   = b;
            op.due = edgeCount + BITS - 1;
            pending.push_back(op);
        end
        checkOutput();
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        edgeCount    = 0;
        lastProd     = '0;
        lastZero     = 1'b0;
        reset_n      = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        start4       = 1'b0;
        a4           = '0;
        b4           = '0;

        #2 reset_n = 1'b0;
        #1;
        checkEq("reset_valid", {31'd0, data_valid}, 32'd0);
        checkEq("reset_product", {16'd0, product}, 32'd0);
        checkEq("reset_zero", {31'd0, zero_operand}, 32'd0);
        checkEq("reset_valid4", {31'd0, valid4}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Max operands, issued on the first edge after reset release.
        applyStimulus(1'b1, 8'd255, 8'd255);
        repeat (9) applyStimulus(1'b0, 8'd0, 8'd0);
        checkEq("max_product", {16'd0, product}, 32'h0000FE01);

        // Narrow instance: 15*15 shows up three edges after the sampling edge.
        start4 = 1'b1;
        a4     = 4'd15;
        b4     = 4'd15;
        applyStimulus(1'b0, 8'd0, 8'd0);
        start4 = 1'b0;
        a4     = 4'd3;
        b4     = 4'd0;
        for (int j = 0; j < 6; j++) begin
            checkEq("valid4", {31'd0, valid4}, (j == 3) ? 32'd1 : 32'd0);
            checkEq("product4", {24'd0, product4}, (j >= 3) ? 32'd225 : 32'd0);
            checkEq("zero4", {31'd0, zero4}, 32'd0);
            applyStimulus(1'b0, 8'd0, 8'd0);
        end

        applyStimulus(1'b1, 8'd0, 8'd77);
        repeat (9) applyStimulus(1'b0, 8'd99, 8'd99);
        applyStimulus(1'b1, 8'd13, 8'd0);
        repeat (9) applyStimulus(1'b0, 8'd0, 8'd0);

        applyStimulus(1'b1, 8'd3, 8'd5);
        applyStimulus(1'b1, 8'd16, 8'd16);
        applyStimulus(1'b1, 8'd255, 8'd1);
        applyStimulus(1'b1, 8'd128, 8'd2);
        repeat (10) applyStimulus(1'b0, 8'd0, 8'd0);

        applyStimulus(1'b1, 8'd10, 8'd10);
        applyStimulus(1'b0, 8'd200, 8'd200);
        applyStimulus(1'b1, 8'd7, 8'd9);
        repeat (10) applyStimulus(1'b0, 8'd0, 8'd0);
        checkEq("alt_product", {16'd0, product}, 32'd63);

        // Reset mid-flight: both in-flight operations must vanish.
        applyStimulus(1'b1, 8'd20, 8'd30);
        applyStimulus(1'b1, 8'd40, 8'd50);
        applyStimulus(1'b0, 8'd0, 8'd0);
        applyStimulus(1'b0, 8'd0, 8'd0);
        #1 reset_n = 1'b0;
        #1;
        checkEq("midreset_valid", {31'd0, data_valid}, 32'd0);
        checkEq("midreset_product", {16'd0, product}, 32'd0);
        checkEq("midreset_zero", {31'd0, zero_operand}, 32'd0);
        pending.delete();
        lastProd = '0;
        lastZero = 1'b0;
        applyStimulus(1'b0, 8'd0, 8'd0);
        reset_n = 1'b1;
        repeat (10) applyStimulus(1'b0, 8'd0, 8'd0);
        applyStimulus(1'b1, 8'd6, 8'd7);
        repeat (8) applyStimulus(1'b0, 8'd0, 8'd0);
        checkEq("post_reset_product", {16'd0, product}, 32'd42);

        for (int n = 0; n < 10000; n++) begin
            int unsigned gap;
            int unsigned mode;
            logic [7:0]  ra;
            logic [7:0]  rb;
            gap = $urandom_range(0, 2);
            repeat (gap) applyStimulus(1'b0, 8'($urandom), 8'($urandom));
            mode = $urandom_range(0, 9);
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            if (mode == 0) ra = 8'd0;
            if (mode == 1) rb = 8'd0;
            if (mode == 2) ra = 8'd255;
            if (mode == 3) rb = 8'd255;
            applyStimulus(1'b1, ra, rb);
        end
        repeat (BITS + 2) applyStimulus(1'b0, 8'd0, 8'd0);
        checkEq("drain_pending", pending.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_pipelined.md
MULT_PIPELINED -- requirements
Module: mult_pipelined

Interface
REQ-001 The block SHALL have parameter BITS, default 8, giving the operand width in bits; legal values are 2 to 32.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset_n  input  1  reset; asynchronous and active-low.
REQ-004 start  input  1  operands valid this cycle; one new operation per cycle, no backpressure.
REQ-005 multiplicand  input  BITS  unsigned operand A.
REQ-006 multiplier  input  BITS  unsigned operand B.
REQ-007 product  output  2*BITS  unsigned A*B, registered.
REQ-008 zero_operand  output  1  registered; high when A==0 or B==0 for the result currently presented.
REQ-009 data_valid  output  1  registered; high for exactly one cycle per completed operation.

Function
REQ-010 The block SHALL be a BITS-stage shift-add pipeline; stage i adds (A << i) to the partial sum when bit i of B is 1.
REQ-011 Each stage SHALL carry its own valid bit, A, B and partial sum, so up to BITS operations are in flight.
REQ-012 Operands SHALL be sampled on a rising edge where start=1 (edge 1); no sampling SHALL occur when start=0.
REQ-013 For each sampled operation, data_valid SHALL be high during the cycle after edge BITS.
REQ-014 With BITS=8, that is the cycle between edge 8 and edge 9.
REQ-015 In that same cycle, product SHALL equal A*B with no truncation; the 2*BITS width cannot overflow.
REQ-016 In that same cycle, zero_operand SHALL equal (A==0)||(B==0).
REQ-017 Start high on N consecutive edges SHALL produce data_valid high on N consecutive cycles, with results in issue order.
REQ-018 product and zero_operand SHALL hold the most recent valid result while data_valid=0.
REQ-019 product and zero_operand SHALL NOT change when a bubble reaches the output stage.
REQ-020 Stages holding no valid operation SHALL NOT alter product, zero_operand or data_valid.
REQ-021 Operand values presented while start=0 SHALL have no effect on any output.
REQ-022 Extreme operands SHALL produce exact results: (2^BITS-1)*(2^BITS-1) = 2^(2*BITS) - 2^(BITS+1) + 1.
REQ-023 The pipeline SHALL be free-running: no stall, no flush input, no internal FSM beyond the valid-bit shift chain.
REQ-024 Outputs SHALL be driven only from flops; no combinational path from any input to any output.

Reset
REQ-025 While reset_n=0, the block SHALL asynchronously clear all stage valid bits, product, zero_operand and data_valid to 0.
REQ-026 Stage data registers MAY be left uncleared, provided the outputs of REQ-025 are cleared.
REQ-027 Operations in flight when reset asserts SHALL be discarded; no data_valid pulse for them SHALL ever appear.
REQ-028 After reset_n rises, the first data_valid SHALL occur only BITS edges after the first start sampled post-reset.
REQ-029 start=1 on the first edge after reset_n rises SHALL be accepted normally.

Verification
REQ-030 BITS=8, A=255, B=255, single start -> data_valid high for 1 cycle after 8 edges, product=65025 (0xFE01), zero_operand=0.
REQ-031 BITS=8, A=0, B=77 -> product=0, zero_operand=1; then A=13, B=0 -> product=0, zero_operand=1.
REQ-032 BITS=8, start high 4 consecutive edges with (3,5), (16,16), (255,1), (128,2) -> data_valid high 4 consecutive cycles, products 15, 256, 255, 256 in order.
REQ-033 BITS=8, start high every other edge with (10,10), (7,9) -> data_valid alternates 1,0,1; product shows 100 then 100 (held through the bubble) then 63.
REQ-034 BITS=8, two operations issued, then reset_n pulsed low 1 cycle at edge 4 -> all outputs 0 immediately, no data_valid ever for either operation; a new (6,7) issued after release -> 42 after 8 edges.
REQ-035 BITS=4, A=15, B=15 -> data_valid after 4 edges, product=225.
REQ-036 Random regression: 10,000 random (A,B) pairs with random start gaps -> every product matches a reference model in order.
